// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Registered stage between the traffic controller and the lamp drivers.
// It decodes the encoded main/side/walk signals into one-hot lamp drives.
// It checks every sample against the signalling rules. On the first
// violation it latches a fault code and forces both roads to flashing red
// until reset.
module traffic_light_monitor #(
  parameter int MIN_YELLOW = 2,   // minimum consecutive yellow cycles before red
  parameter int MAX_HOLD   = 32,  // unchanged cycles before a stuck fault, 2..255
  parameter int FLASH_HALF = 4    // cycles per on/off half-period, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] main_light,
  input  logic [1:0] side_light,
  input  logic       walk_light,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk_lamp,
  output logic       dont_walk_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    ILLEGAL = 2'b11
  } light_t;

  // Lower value = higher priority when several rules break at once.
  typedef enum logic [2:0] {
    F_NONE         = 3'd0,
    F_ILLEGAL      = 3'd1,
    F_CONFLICT     = 3'd2,
    F_TRANSITION   = 3'd3,
    F_SHORT_YELLOW = 3'd4,
    F_WALK         = 3'd5,
    F_STUCK        = 3'd6
  } fault_t;

  localparam logic [7:0] MIN_YELLOW_C = 8'(MIN_YELLOW);
  localparam logic [7:0] MAX_HOLD_C   = 8'(MAX_HOLD);
  localparam logic [7:0] FLASH_TERM   = 8'(FLASH_HALF - 1);
  localparam logic [7:0] SAT_MAX      = 8'hff;

  light_t     cur_main;
  light_t     cur_side;
  light_t     prev_main;
  light_t     prev_side;
  logic [7:0] yellow_cnt_main;
  logic [7:0] yellow_cnt_side;
  logic [7:0] hold_cnt;
  logic [7:0] flash_cnt;
  logic       flash_phase;

  logic [7:0] hold_next;
  logic [7:0] yellow_next_main;
  logic [7:0] yellow_next_side;
  fault_t     violation;

  assign cur_main = light_t'(main_light);
  assign cur_side = light_t'(side_light);

  // A road may only hold its colour or advance GREEN->YELLOW->RED->GREEN.
  function automatic logic bad_step(input light_t prev, input light_t cur);
    return (prev == GREEN  && cur == RED)    ||
           (prev == YELLOW && cur == GREEN)  ||
           (prev == RED    && cur == YELLOW);
  endfunction

  // Yellow ended early: this sample is red, the last was yellow, too few yellows.
  function automatic logic short_yellow(input light_t prev, input light_t cur,
                                        input logic [7:0] cnt);
    return (prev == YELLOW) && (cur == RED) && (cnt < MIN_YELLOW_C);
  endfunction

  function automatic logic [2:0] decode(input light_t code);
    case (code)
      GREEN:   return 3'b001;
      YELLOW:  return 3'b010;
      RED:     return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SAT_MAX) ? SAT_MAX : v + 8'd1;
  endfunction

  // Evaluate all rules on the current sample against the previous one.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    violation        = F_NONE;
    hold_next        = ({cur_main, cur_side} != {prev_main, prev_side}) ? 8'd0
                                                                        : sat_inc(hold_cnt);
    yellow_next_main = (cur_main == YELLOW) ? sat_inc(yellow_cnt_main) : 8'd0;
    yellow_next_side = (cur_side == YELLOW) ? sat_inc(yellow_cnt_side) : 8'd0;

    if (cur_main == ILLEGAL || cur_side == ILLEGAL)
      violation = F_ILLEGAL;
    else if (cur_main != RED && cur_side != RED)
      violation = F_CONFLICT;
    else if (bad_step(prev_main, cur_main) || bad_step(prev_side, cur_side))
      violation = F_TRANSITION;
    else if (short_yellow(prev_main, cur_main, yellow_cnt_main) ||
             short_yellow(prev_side, cur_side, yellow_cnt_side))
      violation = F_SHORT_YELLOW;
    else if (walk_light && (cur_main != RED || cur_side != RED))
      violation = F_WALK;
    else if (hold_next == MAX_HOLD_C)
      violation = F_STUCK;
  end

  // Normal decode and history tracking, fault latching, and fail-safe flashing.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      main_lamp       <= 3'b001;
      side_lamp       <= 3'b100;
      walk_lamp       <= 1'b0;
      dont_walk_lamp  <= 1'b1;
      fault           <= 1'b0;
      fault_code      <= F_NONE;
      prev_main       <= GREEN;
      prev_side       <= RED;
      yellow_cnt_main <= 8'd0;
      yellow_cnt_side <= 8'd0;
      hold_cnt        <= 8'd0;
      flash_cnt       <= 8'd0;
      flash_phase     <= 1'b1;
    end else if (!fault) begin
      if (violation != F_NONE) begin
        fault          <= 1'b1;
        fault_code     <= violation;
        flash_cnt      <= 8'd0;
        flash_phase    <= 1'b1;
        main_lamp      <= 3'b100;
        side_lamp      <= 3'b100;
        walk_lamp      <= 1'b0;
        dont_walk_lamp <= 1'b1;
      end else begin
        main_lamp       <= decode(cur_main);
        side_lamp       <= decode(cur_side);
        walk_lamp       <= walk_light;
        dont_walk_lamp  <= ~walk_light;
        prev_main       <= cur_main;
        prev_side       <= cur_side;
        yellow_cnt_main <= yellow_next_main;
        yellow_cnt_side <= yellow_next_side;
        hold_cnt        <= hold_next;
      end
    end else begin
      // Fail-safe: inputs ignored, both roads blink red, pedestrians held.
      walk_lamp      <= 1'b0;
      dont_walk_lamp <= 1'b1;
      if (flash_cnt == FLASH_TERM) begin
        flash_cnt   <= 8'd0;
        flash_phase <= ~flash_phase;
        main_lamp   <= {~flash_phase, 2'b00};
        side_lamp   <= {~flash_phase, 2'b00};
      end else begin
        flash_cnt <= flash_cnt + 8'd1;
        main_lamp <= {flash_phase, 2'b00};
        side_lamp <= {flash_phase, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
// Directed scenarios followed by a randomized controller with occasional
// corrupted samples. Outputs are compared every cycle with a reference
// model built from the signalling rules.
module tb_traffic_light_monitor;

  localparam int MIN_YELLOW = 2;
  localparam int MAX_HOLD   = 32;
  localparam int FLASH_HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] main_light = 2'b10;
  logic [1:0] side_light = 2'b00;
  logic       walk_light = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk_lamp;
  logic       dont_walk_lamp;
  logic       fault;
  logic [2:0] fault_code;

  traffic_light_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD  (MAX_HOLD),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .main_light    (main_light),
    .side_light    (side_light),
    .walk_light    (walk_light),
    .main_lamp     (main_lamp),
    .side_lamp     (side_lamp),
    .walk_lamp     (walk_lamp),
    .dont_walk_lamp(dont_walk_lamp),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  always #5 clk = ~clk;

  localparam int R = 0, Y = 1, G = 2, X = 3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, kept in terms of the rules: last sample, length
  // of the current yellow run, length of the current unchanged run, and the
  // number of cycles spent flashing.
  int m_prev_main, m_prev_side;
  int m_yrun_main, m_yrun_side;
  int m_run;
  int m_fault, m_code;
  int m_flash_t;
  logic [2:0] e_main, e_side;
  logic       e_walk, e_dw;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int successor(input int c);
    return (c == G) ? Y : (c == Y) ? R : G;
  endfunction

  function automatic logic [2:0] lamp_of(input int c);
    return (c == G) ? 3'b001 : (c == Y) ? 3'b010 : 3'b100;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model(input int m, input int s, input int w, input int r);
    int code;
    int run_next;
    bit m_ok, s_ok;
    if (r != 0) begin
      m_prev_main = G; m_prev_side = R;
      m_yrun_main = 0; m_yrun_side = 0;
      m_run = 0; m_fault = 0; m_code = 0; m_flash_t = 0;
      e_main = 3'b001; e_side = 3'b100; e_walk = 1'b0; e_dw = 1'b1;
    end else if (m_fault != 0) begin
      m_flash_t++;
      e_main = (((m_flash_t / FLASH_HALF) % 2) == 0) ? 3'b100 : 3'b000;
      e_side = e_main; e_walk = 1'b0; e_dw = 1'b1;
    end else begin
      code = 0;
      run_next = (m == m_prev_main && s == m_prev_side) ? sat(m_run + 1) : 0;
      m_ok = (m == m_prev_main) || (m == successor(m_prev_main));
      s_ok = (s == m_prev_side) || (s == successor(m_prev_side));
      if (m == X || s == X) code = 1;
      else if (m != R && s != R) code = 2;
      else if (!m_ok || !s_ok) code = 3;
      else if ((m_prev_main == Y && m == R && m_yrun_main < MIN_YELLOW) ||
               (m_prev_side == Y && s == R && m_yrun_side < MIN_YELLOW)) code = 4;
      else if (w != 0 && (m != R || s != R)) code = 5;
      else if (run_next >= MAX_HOLD) code = 6;
      if (code != 0) begin
        m_fault = 1; m_code = code; m_flash_t = 0;
        e_main = 3'b100; e_side = 3'b100; e_walk = 1'b0; e_dw = 1'b1;
      end else begin
        e_main = lamp_of(m); e_side = lamp_of(s);
        e_walk = (w != 0); e_dw = (w == 0);
        m_yrun_main = (m == Y) ? sat(m_yrun_main + 1) : 0;
        m_yrun_side = (s == Y) ? sat(m_yrun_side + 1) : 0;
        m_run = run_next;
        m_prev_main = m; m_prev_side = s;
      end
    end
  endtask

  // Apply one sample, advance the model, and compare all outputs after the edge.
  task automatic step(input int m, input int s, input int w, input int r);
    @(negedge clk);
    main_light = 2'(m);
    side_light = 2'(s);
    walk_light = 1'(w);
    rst        = 1'(r);
    @(posedge clk);
    model(m, s, w, r);
    #1;
    check("lamps", {8'd0, main_lamp, side_lamp, walk_lamp, dont_walk_lamp},
                   {8'd0, e_main, e_side, e_walk, e_dw});
    check("fault", {12'd0, fault, fault_code}, {12'd0, 1'(m_fault), 3'(m_code)});
  endtask

  task automatic do_reset();
    step(G, R, 0, 1);
  endtask

  task automatic repeat_step(input int n, input int m, input int s, input int w);
    for (int i = 0; i < n; i++) step(m, s, w, 0);
  endtask

  // Random controller state.
  int ph, rem, flash_lim;

  function automatic int pick_len(input int p);
    case (p)
      0, 3:    return $urandom_range(1, 33);
      1, 4:    return $urandom_range(1, 4);
      default: return $urandom_range(0, 2);
    endcase
  endfunction

  initial begin
    // Reset state.
    do_reset();
    check("reset_main", {13'd0, main_lamp}, 16'h0001);
    check("reset_side", {13'd0, side_lamp}, 16'h0004);

    // 1. Normal cycle with a walk window.
    do_reset();
    repeat_step(12, G, R, 0);
    repeat_step(2, Y, R, 0);
    step(R, R, 1, 0);
    check("t1_walk", {14'd0, walk_lamp, dont_walk_lamp}, 16'h0002);
    repeat_step(6, R, G, 0);
    repeat_step(2, R, Y, 0);
    step(R, R, 0, 0);
    step(G, R, 0, 0);
    check("t1_nofault", {15'd0, fault}, 16'h0000);

    // 2. Conflict, then watch the flashing pattern.
    do_reset();
    repeat_step(3, G, R, 0);
    step(G, G, 0, 0);
    check("t2_code", {13'd0, fault_code}, 16'h0002);
    repeat_step(12, G, R, 1);

    // 3. Bad transition, short yellow, exact minimum yellow.
    do_reset();
    step(G, R, 0, 0);
    step(R, R, 0, 0);
    check("t3_trans", {13'd0, fault_code}, 16'h0003);
    do_reset();
    step(G, R, 0, 0);
    step(Y, R, 0, 0);
    step(R, R, 0, 0);
    check("t3_short", {13'd0, fault_code}, 16'h0004);
    do_reset();
    step(G, R, 0, 0);
    repeat_step(2, Y, R, 0);
    step(R, R, 0, 0);
    check("t3_minyel", {15'd0, fault}, 16'h0000);

    // 4. Walk unsafe, priority, stickiness.
    do_reset();
    step(G, R, 1, 0);
    check("t4_walk", {13'd0, fault_code}, 16'h0005);
    do_reset();
    step(G, X, 1, 0);
    check("t4_prio", {13'd0, fault_code}, 16'h0001);
    step(G, G, 0, 0);
    check("t4_sticky", {13'd0, fault_code}, 16'h0001);

    // 5. Stuck detection and its near miss.
    do_reset();
    repeat_step(MAX_HOLD - 1, G, R, 0);
    check("t5_before", {15'd0, fault}, 16'h0000);
    step(G, R, 0, 0);
    check("t5_stuck", {13'd0, fault_code}, 16'h0006);
    do_reset();
    repeat_step(MAX_HOLD - 2, G, R, 0);
    repeat_step(2, Y, R, 0);
    step(R, R, 0, 0);
    step(R, G, 0, 0);
    check("t5_nostuck", {15'd0, fault}, 16'h0000);

    // 6. Reset in the middle of flashing, then a legal run.
    do_reset();
    step(G, G, 0, 0);
    repeat_step(6, R, R, 0);
    do_reset();
    check("t6_rst", {9'd0, fault, fault_code, main_lamp}, 16'h0001);
    repeat_step(4, G, R, 0);
    repeat_step(3, Y, R, 0);
    step(R, R, 0, 0);
    repeat_step(5, R, G, 0);
    repeat_step(2, R, Y, 0);
    step(R, R, 0, 0);
    check("t6_legal", {15'd0, fault}, 16'h0000);

    // Randomized controller with occasional corrupted samples.
    do_reset();
    ph = 0; rem = pick_len(0); flash_lim = $urandom_range(0, 20);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int m, s, w;
      if (m_fault != 0 && m_flash_t >= flash_lim) begin
        do_reset();
        ph = 0; rem = pick_len(0); flash_lim = $urandom_range(0, 20);
        continue;
      end
      while (rem == 0) begin
        ph = (ph + 1) % 6;
        rem = pick_len(ph);
      end
      case (ph)
        0:       begin m = G; s = R; end
        1:       begin m = Y; s = R; end
        3:       begin m = R; s = G; end
        4:       begin m = R; s = Y; end
        default: begin m = R; s = R; end
      endcase
      w = (ph == 2 || ph == 5) ? int'($urandom_range(0, 1)) : 0;
      if ($urandom_range(0, 99) < 2) begin
        m = $urandom_range(0, 3);
        s = $urandom_range(0, 3);
        w = $urandom_range(0, 1);
      end
      rem--;
      step(m, s, w, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
